// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet round-robin arbiter feeding the UART TX stream sink
module uart_tx_arbiter #(
    parameter int                    NUM_SRC    = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    HEADER_EN  = 1,
    parameter logic [DATA_WIDTH-5:0] HDR_TAG    = 4'hA,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]              s_tvalid,
    output logic [NUM_SRC-1:0]              s_tready,
    input  logic [NUM_SRC-1:0]              s_tlast,
    output logic [DATA_WIDTH-1:0]           m_tdata,
    output logic                            m_tvalid,
    input  logic                            m_tready,
    output logic                            m_tlast,
    output logic [$clog2(NUM_SRC)-1:0]      grant_id,
    output logic                            busy,
    output logic                            timeout_err
);
    localparam int IDW = $clog2(NUM_SRC);
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PAYLOAD
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [WDW-1:0]   wd_cnt_q, wd_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    logic                  pick_found;
    logic [IDW-1:0]        pick_idx;
    logic [IDW-1:0]        cand;
    logic [DATA_WIDTH-1:0] hdr_byte;
    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src_data
        assign src_data[g] = s_tdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    assign hdr_byte    = {HDR_TAG, 4'(grant_id_q)};
    assign grant_id    = grant_id_q;
    assign timeout_err = timeout_err_q;

    // Round-robin search starting one past the last served source
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = IDW'((int'(rr_ptr_q) + i) % NUM_SRC);
            if (!pick_found && s_tvalid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Next-state, datapath mux and watchdog
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_id_d    = grant_id_q;
        wd_cnt_d      = '0;
        timeout_err_d = 1'b0;
        m_tvalid      = 1'b0;
        m_tdata       = '0;
        m_tlast       = 1'b0;
        s_tready      = '0;
        busy          = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    state_d    = (HEADER_EN != 0) ? ST_HEADER : ST_PAYLOAD;
                end
            end
            ST_HEADER: begin
                busy     = 1'b1;
                m_tvalid = 1'b1;
                m_tdata  = hdr_byte;
                if (m_tready) begin
                    state_d = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                busy                 = 1'b1;
                m_tvalid             = s_tvalid[grant_id_q];
                m_tdata              = src_data[grant_id_q];
                m_tlast              = s_tlast[grant_id_q];
                s_tready[grant_id_q] = m_tready;
                wd_cnt_d             = wd_cnt_q;
                if (s_tvalid[grant_id_q] && m_tready) begin
                    wd_cnt_d = '0;
                    if (s_tlast[grant_id_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_id_q;
                    end
                end else if ((TIMEOUT > 0) && !s_tvalid[grant_id_q]) begin
                    // Stalled source: release the grant without a synthetic tlast
                    if (wd_cnt_q == WD_LAST) begin
                        state_d       = ST_IDLE;
                        rr_ptr_d      = grant_id_q;
                        timeout_err_d = 1'b1;
                        wd_cnt_d      = '0;
                    end else if (wd_cnt_q != '1) begin
                        wd_cnt_d = wd_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            rr_ptr_q      <= IDW'(NUM_SRC - 1);
            grant_id_q    <= '0;
            wd_cnt_q      <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            wd_cnt_q      <= wd_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NS*DW-1:0] s_tdata, s_tdata2;
    logic [NS-1:0] s_tvalid, s_tready, s_tlast;
    logic [NS-1:0] s_tvalid2, s_tready2, s_tlast2;
    logic [DW-1:0] m_tdata, m_tdata2;
    logic          m_tvalid, m_tready, m_tlast;
    logic          m_tvalid2, m_tready2, m_tlast2;
    logic [1:0]    grant_id, grant_id2;
    logic          busy, busy2, timeout_err, timeout_err2;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .HEADER_EN(1), .HDR_TAG(4'hA), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
    );

    uart_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .HEADER_EN(0), .HDR_TAG(4'hA), .TIMEOUT(TO)) dut_nh (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata2), .s_tvalid(s_tvalid2), .s_tready(s_tready2), .s_tlast(s_tlast2),
        .m_tdata(m_tdata2), .m_tvalid(m_tvalid2), .m_tready(m_tready2), .m_tlast(m_tlast2),
        .grant_id(grant_id2), .busy(busy2), .timeout_err(timeout_err2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_mode = 0;
    int busy_cnt = 0;
    int last_beat_cyc = 0;

    logic [8:0]  srcq [NS][$];
    logic [8:0]  srcq2 [$];
    logic [12:0] expq [$];
    logic [8:0]  expq2 [$];
    int          beat2_cyc [$];
    bit          fire [NS];
    bit          fire2;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input int src, input logic [7:0] b[$], input bit with_last);
        for (int i = 0; i < b.size(); i++)
            srcq[src].push_back({with_last && (i == b.size() - 1), b[i]});
    endtask

    task automatic expect_pkt(input int src, input logic [7:0] b[$], input bit with_last);
        expq.push_back({1'b1, 3'(src), 1'b0, 8'hA0 | 8'(src)});
        for (int i = 0; i < b.size(); i++)
            expq.push_back({1'b0, 3'(src), with_last && (i == b.size() - 1), b[i]});
    endtask

    function automatic bit all_empty();
        bit e;
        e = (expq.size() == 0) && (srcq2.size() == 0) && (expq2.size() == 0);
        for (int s = 0; s < NS; s++) if (srcq[s].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic wait_done(input int maxc, input string name);
        int n;
        n = 0;
        while (!all_empty() && n < maxc) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (!all_empty()) begin
            errors++;
            $display("FAIL %s_drain: %0d beats left after %0d cycles, required 0", name, expq.size() + expq2.size(), maxc);
        end
        repeat (2) @(posedge clk);
    endtask

    // Source and sink driver: pops on handshakes seen just before the previous edge
    initial begin
        s_tvalid = '0; s_tdata = '0; s_tlast = '0; m_tready = 1'b0;
        s_tvalid2 = '0; s_tdata2 = '0; s_tlast2 = '0; m_tready2 = 1'b1;
        fire2 = 1'b0;
        for (int s = 0; s < NS; s++) fire[s] = 1'b0;
        forever begin
            @(negedge clk);
            for (int s = 0; s < NS; s++)
                if (fire[s] && srcq[s].size() > 0) srcq[s].delete(0);
            if (fire2 && srcq2.size() > 0) srcq2.delete(0);
            case (rdy_mode)
                0:       m_tready = 1'b1;
                1:       m_tready = 1'($urandom_range(0, 1));
                default: m_tready = 1'b0;
            endcase
            for (int s = 0; s < NS; s++) begin
                if (srcq[s].size() > 0) begin
                    s_tvalid[s] = 1'b1;
                    s_tdata[s*DW +: DW] = srcq[s][0][7:0];
                    s_tlast[s] = srcq[s][0][8];
                end else begin
                    s_tvalid[s] = 1'b0;
                    s_tdata[s*DW +: DW] = '0;
                    s_tlast[s] = 1'b0;
                end
            end
            s_tvalid2[0] = (srcq2.size() > 0);
            s_tdata2[DW-1:0] = (srcq2.size() > 0) ? srcq2[0][7:0] : 8'h00;
            s_tlast2[0] = (srcq2.size() > 0) ? srcq2[0][8] : 1'b0;
            #1;
            for (int s = 0; s < NS; s++) fire[s] = s_tvalid[s] && s_tready[s] && rst_n;
            fire2 = s_tvalid2[0] && s_tready2[0] && rst_n;
        end
    end

    // Monitor for the header-enabled instance
    always @(negedge clk) begin
        logic [12:0] e;
        #2;
        if (rst_n) begin
            if (busy) busy_cnt++;
            if (busy && m_tvalid && expq.size() > 0) begin
                e = expq[0];
                chk("s_tready_mask", 32'(s_tready), e[12] ? 32'h0 : (32'(m_tready) << e[10:9]));
            end
            if (m_tvalid && m_tready) begin
                last_beat_cyc = cyc;
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_unexpected: got data=0x%0h last=%0b, required no beat", m_tdata, m_tlast);
                end else begin
                    e = expq.pop_front();
                    chk("m_beat", {23'h0, m_tlast, m_tdata}, {23'h0, e[8:0]});
                    chk("grant_id", 32'(grant_id), 32'(e[10:9]));
                end
            end
        end
    end

    // Monitor for the header-less instance
    always @(negedge clk) begin
        logic [8:0] e2;
        #2;
        if (rst_n && m_tvalid2 && m_tready2) begin
            beat2_cyc.push_back(cyc);
            if (expq2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL nh_beat_unexpected: got data=0x%0h, required no beat", m_tdata2);
            end else begin
                e2 = expq2.pop_front();
                chk("nh_beat", {23'h0, m_tlast2, m_tdata2}, {23'h0, e2});
            end
        end
    end

    initial begin
        logic [7:0] b[$];
        bit seen;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #3;
        chk("rst_outputs", {s_tready, m_tvalid, m_tlast, m_tdata, grant_id, busy, timeout_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // T3: four requesters, src0 holds two packets
        @(posedge clk);
        b = {8'h00, 8'h01}; send(0, b, 1'b1); expect_pkt(0, b, 1'b1);
        b = {8'h10, 8'h11}; send(1, b, 1'b1); expect_pkt(1, b, 1'b1);
        b = {8'h20, 8'h21}; send(2, b, 1'b1); expect_pkt(2, b, 1'b1);
        b = {8'h30, 8'h31}; send(3, b, 1'b1); expect_pkt(3, b, 1'b1);
        b = {8'h02, 8'h03}; send(0, b, 1'b1); expect_pkt(0, b, 1'b1);
        wait_done(200, "t3");

        // T2: src1 three bytes, busy spans header plus payload
        busy_cnt = 0;
        b = {8'h11, 8'h22, 8'h33}; send(1, b, 1'b1); expect_pkt(1, b, 1'b1);
        wait_done(100, "t2");
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd4);

        // T4: random sink backpressure on a src2 packet
        rdy_mode = 1;
        b = {8'h51, 8'h52, 8'h53, 8'h54, 8'h55}; send(2, b, 1'b1); expect_pkt(2, b, 1'b1);
        wait_done(400, "t4");
        rdy_mode = 0;

        // T5: src3 stalls mid-packet, watchdog releases the grant
        b = {8'h3F}; send(3, b, 1'b0); expect_pkt(3, b, 1'b0);
        wait_done(100, "t5");
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk); #3;
            seen = timeout_err;
        end
        chk("t5_timeout_seen", 32'(seen), 32'd1);
        chk("t5_timeout_cycle", 32'(cyc - last_beat_cyc), 32'(TO + 1));
        chk("t5_idle_on_pulse", 32'(busy), 32'd0);
        @(negedge clk); #3;
        chk("t5_pulse_width", 32'(timeout_err), 32'd0);
        @(posedge clk);
        b = {8'h3E}; send(3, b, 1'b1);
        b = {8'h0E}; send(0, b, 1'b1); expect_pkt(0, b, 1'b1);
        b = {8'h3E}; expect_pkt(3, b, 1'b1);
        wait_done(100, "t5b");

        // T1: reset while src2 holds the grant mid-payload
        b = {8'h2A}; send(2, b, 1'b0); expect_pkt(2, b, 1'b0);
        wait_done(100, "t1");
        chk("t1_busy_before_reset", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int s = 0; s < NS; s++) begin
            srcq[s].delete();
            fire[s] = 1'b0;
        end
        expq.delete();
        @(negedge clk); #3;
        chk("t1_rst_outputs", {s_tready, m_tvalid, m_tlast, m_tdata, grant_id, busy, timeout_err}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        b = {8'h2B}; send(2, b, 1'b1);
        b = {8'h0B}; send(0, b, 1'b1); expect_pkt(0, b, 1'b1);
        b = {8'h2B}; expect_pkt(2, b, 1'b1);
        wait_done(100, "t1b");

        // T6: header-less instance, two single-beat packets from src0
        beat2_cyc.delete();
        srcq2.push_back({1'b1, 8'h01}); expq2.push_back({1'b1, 8'h01});
        srcq2.push_back({1'b1, 8'h02}); expq2.push_back({1'b1, 8'h02});
        wait_done(100, "t6");
        chk("t6_beat_count", 32'(beat2_cyc.size()), 32'd2);
        if (beat2_cyc.size() == 2)
            chk("t6_bubble_gap", 32'(beat2_cyc[1] - beat2_cyc[0]), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1);
    end
endmodule
